// File: rtl/octal_sub_pkg.sv
// Shared types and constants for the digit-serial octal subtractor.
package octal_sub_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StNegate,
    StDone
  } state_e;

  localparam int unsigned DefDigitW  = 3;
  localparam int unsigned DefNDigits = 4;

  // Digit index width; never narrower than one bit, even for a single digit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned DefIdxW = idx_w(DefNDigits);

endpackage

// File: rtl/octal_serial_sub_digit_sub.sv
// One-digit ripple-borrow subtractor: {brw_out, d} = x - y - brw_in.
// Built as a chain of single-bit full-subtractor cells.
module digit_sub #(
  parameter int unsigned DIGIT_W = 3
) (
  input  logic [DIGIT_W-1:0] x,
  input  logic [DIGIT_W-1:0] y,
  input  logic               brw_in,
  output logic [DIGIT_W-1:0] d,
  output logic               brw_out
);

  logic [DIGIT_W:0] chain;

  assign chain[0] = brw_in;

  for (genvar i = 0; i < DIGIT_W; i++) begin : g_cell
    // Full-subtractor cell: borrow out when x < y + borrow in.
    assign d[i]       = x[i] ^ y[i] ^ chain[i];
    assign chain[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & chain[i]);
  end

  assign brw_out = chain[DIGIT_W];

endmodule

// File: rtl/octal_serial_sub.sv
// Digit-serial multi-digit subtractor, LSD first, one digit per clock.
// Optional feature macro: OCTAL_SUB_ABS_EN adds a digit-serial negate pass so
// that diff reports the magnitude and neg the sign of a negative result.
module octal_serial_sub
  import octal_sub_pkg::*;
#(
  parameter int unsigned DIGIT_W = DefDigitW,
  parameter int unsigned NDIGITS = DefNDigits
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [DIGIT_W*NDIGITS-1:0] a,
  input  logic [DIGIT_W*NDIGITS-1:0] b,
  input  logic                       bin,
  output logic                       busy,
  output logic                       done,
  output logic [DIGIT_W*NDIGITS-1:0] diff,
  output logic                       bout,
  output logic                       neg
);

  localparam int unsigned W  = DIGIT_W * NDIGITS;
  localparam int unsigned IW = idx_w(NDIGITS);

  state_e            state_q;
  logic [W-1:0]      a_q, b_q, diff_q;
  logic [IW-1:0]     k_q;
  logic              brw_q, bout_q, busy_q, done_q;

  logic [DIGIT_W-1:0] a_dig, b_dig, run_d;
  logic               run_bo;
  logic               last_dig;

  assign last_dig = (k_q == IW'(NDIGITS - 1));

  // Select operand digit k for the run-pass subtractor.
  always_comb begin
    a_dig = '0;
    b_dig = '0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (k_q == IW'(i)) begin
        a_dig = a_q[i*DIGIT_W +: DIGIT_W];
        b_dig = b_q[i*DIGIT_W +: DIGIT_W];
      end
    end
  end

  digit_sub #(
    .DIGIT_W (DIGIT_W)
  ) u_run_sub (
    .x       (a_dig),
    .y       (b_dig),
    .brw_in  (brw_q),
    .d       (run_d),
    .brw_out (run_bo)
  );

`ifdef OCTAL_SUB_ABS_EN
  logic               neg_q;
  logic [DIGIT_W-1:0] diff_dig, neg_d;
  logic               neg_bo;

  // Select result digit k for the negate pass.
  always_comb begin
    diff_dig = '0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (k_q == IW'(i)) diff_dig = diff_q[i*DIGIT_W +: DIGIT_W];
    end
  end

  // Negate pass reuses brw_q as the running borrow, computing 0 - diff[k] - nb.
  digit_sub #(
    .DIGIT_W (DIGIT_W)
  ) u_neg_sub (
    .x       ({DIGIT_W{1'b0}}),
    .y       (diff_dig),
    .brw_in  (brw_q),
    .d       (neg_d),
    .brw_out (neg_bo)
  );

  assign neg = neg_q;
`else
  assign neg = 1'b0;
`endif

  // Control FSM with registered outputs; DONE accepts a new start like IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      k_q     <= '0;
      brw_q   <= 1'b0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef OCTAL_SUB_ABS_EN
      neg_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle, StDone: begin
          state_q <= StIdle;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            brw_q   <= bin;
            k_q     <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= StRun;
`ifdef OCTAL_SUB_ABS_EN
            neg_q   <= 1'b0;
`endif
          end
        end
        StRun: begin
          for (int i = 0; i < NDIGITS; i++) begin
            if (k_q == IW'(i)) diff_q[i*DIGIT_W +: DIGIT_W] <= run_d;
          end
          brw_q <= run_bo;
          k_q   <= k_q + 1'b1;
          if (last_dig) begin
            bout_q <= run_bo;
            k_q    <= '0;
`ifdef OCTAL_SUB_ABS_EN
            if (run_bo) begin
              state_q <= StNegate;
              brw_q   <= 1'b0;
            end else begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
`else
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
`endif
          end
        end
`ifdef OCTAL_SUB_ABS_EN
        StNegate: begin
          for (int i = 0; i < NDIGITS; i++) begin
            if (k_q == IW'(i)) diff_q[i*DIGIT_W +: DIGIT_W] <= neg_d;
          end
          brw_q <= neg_bo;
          k_q   <= k_q + 1'b1;
          if (last_dig) begin
            k_q     <= '0;
            neg_q   <= 1'b1;
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_octal_serial_sub.sv
// Directed self-checking bench for octal_serial_sub (4 octal digits).
// Expected values switch on OCTAL_SUB_ABS_EN so either build can be checked.
module tb_octal_serial_sub;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [11:0] a, b;
  logic        bin;
  logic        busy, done, bout, neg;
  logic [11:0] diff;

  int n_checks = 0;
  int n_pass   = 0;

  // Captured at the first done pulse of a monitor window.
  logic [11:0] r_diff;
  logic        r_bout, r_neg, r_busy;

  octal_serial_sub #(
    .DIGIT_W (3),
    .NDIGITS (4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .neg   (neg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Watch ncyc cycles (sampled at negedge) counting busy and done cycles.
  task automatic monitor(input int ncyc, output int first_done, output int ndone,
                         output int nbusy);
    first_done = 0;
    ndone      = 0;
    nbusy      = 0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        if (first_done == 0) begin
          first_done = c;
          r_diff = diff;
          r_bout = bout;
          r_neg  = neg;
          r_busy = busy;
        end
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [11:0] av, input logic [11:0] bv,
                        input logic bi, input logic [11:0] ed, input logic eb,
                        input logic en, input int lat);
    int fd, nd, nb;
    @(negedge clk);
    a = av; b = bv; bin = bi; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    monitor(lat + 3, fd, nd, nb);
    check({tag, " done_cycle"}, fd, lat);
    check({tag, " done_count"}, nd, 1);
    check({tag, " busy_cycles"}, nb, lat - 1);
    check({tag, " busy_at_done"}, r_busy, 1'b0);
    check({tag, " diff"}, r_diff, ed);
    check({tag, " bout"}, r_bout, eb);
    check({tag, " neg"}, r_neg, en);
  endtask

  initial begin
    int fd, nd, nb, first;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset diff", diff, 12'o0000);
    check("reset bout", bout, 1'b0);
    check("reset neg", neg, 1'b0);

    run_op("pos", 12'o1234, 12'o0567, 1'b0, 12'o0445, 1'b0, 1'b0, 5);
    run_op("binpos", 12'o0010, 12'o0001, 1'b1, 12'o0006, 1'b0, 1'b0, 5);
    run_op("maxmin", 12'o7777, 12'o0000, 1'b0, 12'o7777, 1'b0, 1'b0, 5);
`ifdef OCTAL_SUB_ABS_EN
    run_op("zm1", 12'o0000, 12'o0001, 1'b0, 12'o0001, 1'b1, 1'b1, 9);
    run_op("eqbin", 12'o7777, 12'o7777, 1'b1, 12'o0001, 1'b1, 1'b1, 9);
    run_op("wrap", 12'o0000, 12'o7777, 1'b1, 12'o0000, 1'b1, 1'b1, 9);
`else
    run_op("zm1", 12'o0000, 12'o0001, 1'b0, 12'o7777, 1'b1, 1'b0, 5);
    run_op("eqbin", 12'o7777, 12'o7777, 1'b1, 12'o7777, 1'b1, 1'b0, 5);
    run_op("wrap", 12'o0000, 12'o7777, 1'b1, 12'o0000, 1'b1, 1'b0, 5);
`endif

    // Start pulsed mid-run is ignored; start on the done cycle is accepted.
    @(negedge clk);
    a = 12'o1234; b = 12'o0567; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);                       // cycle 1
    @(negedge clk);                       // cycle 2
    a = 12'o7777; b = 12'o0000; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    first = 0;
    for (int c = 3; c <= 12; c++) begin
      @(negedge clk);
      if (done) begin
        first  = c;
        r_diff = diff;
        a = 12'o0100; b = 12'o0001; bin = 1'b0; start = 1'b1;
        break;
      end
    end
    check("ignore done_cycle", first, 5);
    check("ignore diff", r_diff, 12'o0445);
    @(posedge clk);
    #1 start = 1'b0;
    monitor(8, fd, nd, nb);
    check("b2b done_cycle", fd, 5);
    check("b2b done_count", nd, 1);
    check("b2b diff", r_diff, 12'o0077);

    // Reset during cycle 3 of a run aborts it with no done pulse.
    @(negedge clk);
    a = 12'o1234; b = 12'o0567; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);                       // E1
    @(posedge clk);                       // E2, now in cycle 3
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort busy", busy, 1'b0);
    check("abort done", done, 1'b0);
    check("abort diff", diff, 12'o0000);
    check("abort bout", bout, 1'b0);
    check("abort neg", neg, 1'b0);
    monitor(10, fd, nd, nb);
    check("abort no_done", nd, 0);
    check("abort no_busy", nb, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
